// File: rtl/sd_write_rawdata.sv
// sd_write_rawdata: streams raw pixels from the DDR read FIFO into SD sectors.
// Each 256-word sector is buffered locally, then served word by word on wr_req.
module sd_write_rawdata #(
   parameter int SEC_WORDS = 256,
   parameter int CNT_W     = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      start_sec_addr,
   input  logic [CNT_W-1:0] sd_sec_num,
   input  logic             ddr_rd_empty,
   output logic             ddr_rd_en,
   input  logic [15:0]      ddr_rd_data,
   input  logic             wr_busy,
   input  logic             wr_req,
   output logic             wr_start_en,
   output logic [31:0]      wr_sec_addr,
   output logic [15:0]      wr_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] sec_cnt
);

   localparam int AW = $clog2(SEC_WORDS);
   localparam int IW = AW + 1;
   localparam logic [IW-1:0]    FULL  = IW'(SEC_WORDS);
   localparam logic [IW-1:0]    LAST  = IW'(SEC_WORDS - 1);
   localparam logic [IW-1:0]    ONE_I = IW'(1);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      START,
      WAIT_BUSY,
      WRITE,
      WAIT_DONE
   } state_t;

   state_t state, nstate;

   logic [15:0]      mem [SEC_WORDS];
   logic [15:0]      rdata;
   logic [31:0]      base;
   logic [CNT_W-1:0] num;
   logic [CNT_W-1:0] sec_inc;
   logic [IW-1:0]    issued;
   logic [IW-1:0]    captured;
   logic [IW-1:0]    word_idx;
   logic             rd_pend;
   logic             wr_busy_q;
   logic             fall;
   logic             cap;
   logic             last_sec;
   logic             accept;
   logic             load_addr;
   logic             serve;
   logic             sec_end;
   logic             fail;
   logic             clr_fill;

   assign busy     = (state != IDLE);
   assign wr_data  = rdata;
   assign fall     = wr_busy_q & ~wr_busy;
   assign cap      = rd_pend & (state == FILL);
   assign sec_inc  = sec_cnt + ONE_C;
   assign last_sec = (sec_inc == num);
   assign clr_fill = accept | (sec_end & ~last_sec);

   // Next-state and per-cycle strobes.
   always_comb begin
      nstate      = state;
      ddr_rd_en   = 1'b0;
      wr_start_en = 1'b0;
      accept      = 1'b0;
      load_addr   = 1'b0;
      serve       = 1'b0;
      sec_end     = 1'b0;
      fail        = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (sd_sec_num != '0) nstate = FILL;
            end
         end
         FILL: begin
            ddr_rd_en = ~ddr_rd_empty & (issued != FULL);
            if (cap && captured == LAST) begin
               nstate    = START;
               load_addr = 1'b1;
            end
         end
         START: begin
            wr_start_en = 1'b1;
            nstate      = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (wr_busy) nstate = WRITE;
         end
         WRITE: begin
            serve = wr_req;
            if (fall) begin
               if (wr_req && word_idx == LAST) sec_end = 1'b1;
               else fail = 1'b1;
            end else if (wr_req && word_idx == LAST) begin
               nstate = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (fall) sec_end = 1'b1;
         end
         default: nstate = IDLE;
      endcase
      if (sec_end) nstate = last_sec ? IDLE : FILL;
      if (fail) nstate = IDLE;
   end

   // State register, counters and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         base        <= '0;
         num         <= '0;
         sec_cnt     <= '0;
         err         <= 1'b0;
         done        <= 1'b0;
         issued      <= '0;
         captured    <= '0;
         word_idx    <= '0;
         rd_pend     <= 1'b0;
         wr_busy_q   <= 1'b0;
         wr_sec_addr <= '0;
      end else begin
         state     <= nstate;
         rd_pend   <= ddr_rd_en;
         wr_busy_q <= wr_busy;
         done      <= 1'b0;
         if (accept) begin
            base    <= start_sec_addr;
            num     <= sd_sec_num;
            sec_cnt <= '0;
            err     <= 1'b0;
            done    <= (sd_sec_num == '0);
         end
         if (clr_fill) begin
            issued   <= '0;
            captured <= '0;
            word_idx <= '0;
         end else begin
            if (ddr_rd_en) issued <= issued + ONE_I;
            if (cap) captured <= captured + ONE_I;
            if (serve) word_idx <= word_idx + ONE_I;
         end
         if (load_addr) wr_sec_addr <= base + 32'(sec_cnt);
         if (sec_end) begin
            sec_cnt <= sec_inc;
            done    <= last_sec;
         end
         if (fail) err <= 1'b1;
      end
   end

   // Sector buffer write port.
   always_ff @(posedge clk) begin
      if (cap) mem[captured[AW-1:0]] <= ddr_rd_data;
   end

   // Registered read port; holds the last word between requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else if (serve) rdata <= mem[word_idx[AW-1:0]];
   end

endmodule

// File: doc/sd_write_rawdata.md
Name: sd_write_rawdata

Overview:
- Frame-capture writer. Streams raw 16-bit pixel data out of the DDR read FIFO and writes it to consecutive SD-card sectors through the write port of sd_ctrl_top.
- It is the write-direction counterpart of read_rawdata. It runs in the clk_sd domain.
- Each sector of 256 words is first buffered locally. It is then handed to the SD controller word by word on wr_req.

Parameters:
- SEC_WORDS, 256: 16-bit words per 512-byte sector.
- CNT_W, 26: width of the sector count and sector index.

Ports:
- clk  in  1: SD reference clock (clk_sd).
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: one-cycle pulse that begins a capture. Ignored while busy=1.
- start_sec_addr  in  32: first SD sector address, sampled on start.
- sd_sec_num  in  CNT_W: number of sectors to write, sampled on start.
- ddr_rd_empty  in  1: source FIFO empty.
- ddr_rd_en  out  1: source FIFO read strobe.
- ddr_rd_data  in  16: source data, valid exactly 1 cycle after ddr_rd_en.
- wr_busy  in  1: SD controller write in progress.
- wr_req  in  1: SD controller word request.
- wr_start_en  out  1: one-cycle sector write start pulse.
- wr_sec_addr  out  32: sector address for the current write.
- wr_data  out  16: word to the SD controller.
- busy  out  1: capture in progress.
- done  out  1: one-cycle pulse, all sectors written.
- err  out  1: sticky error flag, cleared by start.
- sec_cnt  out  CNT_W: sectors completed.

Behaviour:
- Reset values: all outputs are 0. The state is IDLE.
- Sector buffer is a 256x16 RAM with a synchronous read port.

State machine:
- IDLE:
  - On start, latch the address and count. Set busy=1, sec_cnt=0, err=0.
  - If sd_sec_num==0, pulse done on the next cycle and stay in IDLE.
  - Otherwise go to FILL.
- FILL:
  - Assert ddr_rd_en in a cycle only when ddr_rd_empty=0 and issued<256. The issued count is a 9-bit counter.
  - Write ddr_rd_data into buffer[captured] one cycle after each ddr_rd_en.
  - When the 256th word has been captured, go to START.
  - If the FIFO is empty, FILL stalls indefinitely with no error.
- START:
  - Drive wr_sec_addr = base + sec_cnt, modulo 2^32.
  - Pulse wr_start_en for exactly 1 cycle, then go to WAIT_BUSY.
- WAIT_BUSY: when wr_busy rises, go to WRITE.
- WRITE:
  - Each wr_req reads buffer[word_idx] and increments word_idx.
  - wr_data becomes valid the cycle after wr_req and holds until the next read.
  - After the 256th wr_req, go to WAIT_DONE.
  - wr_req pulses after the 256th are ignored; wr_data holds.
- WAIT_DONE: on the falling edge of wr_busy, increment sec_cnt.
  - If sec_cnt == sd_sec_num, pulse done, clear busy and go to IDLE.
  - Otherwise go to FILL and reset the fill counters.

Error and boundary behaviour:
- If wr_busy falls while in WRITE with fewer than 256 words served: set err=1, clear busy and go to IDLE. No done pulse is issued.
- wr_req and a wr_busy fall in the same cycle in WRITE: service the word first, then evaluate the 256-word condition.
- start while busy=1 has no effect.
- An asynchronous reset mid-capture returns to IDLE immediately. No further wr_start_en is issued.
- Latency:
  - start to the first ddr_rd_en is 1 cycle, given a non-empty FIFO.
  - Capture of the last word to wr_start_en is 1 cycle.

Test Plan:
- Single sector: FIFO preloaded with 0x0000..0x00FF, start_sec_addr=0x1000, sd_sec_num=1. Controller model issues 256 wr_req. Required: one wr_start_en with wr_sec_addr=0x1000, wr_data sequence 0x0000..0x00FF, done 1 cycle after wr_busy falls, sec_cnt=1.
- Multi sector: sd_sec_num=3, base=0xFFFFFFFF. Required: wr_sec_addr values 0xFFFFFFFF, 0x00000000, 0x00000001 (wrap-around), 768 words in order, sec_cnt=3.
- FIFO starvation: ddr_rd_empty toggles every 4 cycles during FILL. Required: ddr_rd_en is never high while empty=1, no word is lost or duplicated, and the sector content is still sequential.
- Early busy drop: wr_busy falls after 100 wr_req. Required: err=1, busy=0, no done pulse, return to IDLE. A following start clears err.
- Zero count and start while busy: sd_sec_num=0 -> done 1 cycle after start, with no ddr_rd_en and no wr_start_en. A second start during a 2-sector run is ignored and sec_cnt ends at 2.
- Reset mid-WRITE: assert rst_n=0 after 50 wr_req. Required: all outputs are 0 asynchronously, and there is no wr_start_en after release until a new start.
